uart_tx_fifo_core: RTL and testbench

- 8N1 UART transmitter; companion to the existing 8x-oversampling UART receiver; shares the same i_baud programming.
- Byte-wide valid/ready write port feeds an internal FIFO.
- Serializer drains the FIFO: LSB-first, start bit low, stop bit(s) high.
- Drives the MIDI/debug serial output pin.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_fifo_core_if.sv | 11 +
 rtl/uart_sync_fifo.sv | 55 +++++
 rtl/uart_tx_fifo_core.sv | 137 +++++++++++++
 tb/tb_uart_tx_fifo_core.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states and frame geometry.
// Used by the transmitter here and usable by the companion receiver.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

   localparam int   OVERSAMPLE = 8;
   localparam int   DATA_BITS  = 8;
   localparam logic LINE_IDLE  = 1'b1;

endpackage

// File: rtl/uart_tx_fifo_core_if.sv
// Byte-wide valid/ready write port into the UART transmitter FIFO.
interface uart_tx_fifo_core_if;

   logic       i_txValid;
   logic [7:0] i_txData;
   logic       o_txReady;

   modport master (output i_txValid, output i_txData, input o_txReady);
   modport slave  (input i_txValid, input i_txData, output o_txReady);

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO; push while full and pop while empty are ignored.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   i_clk,
   input  logic                   i_res,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_data,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd_ptr];

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_res) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/uart_tx_fifo_core.sv
// 8N1 UART transmitter: FIFO-buffered write port, 8x-tick baud generator, frame FSM.
// The line output is registered from the current state, so it trails the FSM by one clock.
module uart_tx_fifo_core
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int STOP_BITS  = 1
) (
   input  logic                        i_clk,
   input  logic                        i_res,
   input  logic [15:0]                 i_baud,
   uart_tx_fifo_core_if.slave          io_tx,
   output logic                        o_tx_pin,
   output logic                        o_busy,
   output logic [$clog2(FIFO_DEPTH):0] o_fifoCount
);

   localparam logic [2:0] LAST_TICK = 3'(OVERSAMPLE - 1);
   localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
   localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

   uart_state_e          r_state;
   uart_state_e          w_next;
   logic [DATA_BITS-1:0] r_shift;
   logic [15:0]          r_baud_l;
   logic [15:0]          r_baud_cnt;
   logic [2:0]           r_tick_cnt;
   logic [2:0]           r_bit_cnt;
   logic                 r_stop_cnt;
   logic                 r_tx_pin;

   logic                 w_pop;
   logic                 w_tick;
   logic                 w_bit_end;
   logic                 w_pin_d;
   logic                 w_full;
   logic                 w_empty;
   logic [DATA_BITS-1:0] w_fifo_data;

   uart_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_res   (i_res),
      .i_push  (io_tx.i_txValid),
      .i_data  (io_tx.i_txData),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (o_fifoCount)
   );

   assign io_tx.o_txReady = !w_full;
   assign o_busy          = (r_state != ST_IDLE) || !w_empty;
   assign o_tx_pin        = r_tx_pin;

   assign w_tick    = (r_state != ST_IDLE) && (r_baud_cnt == r_baud_l);
   assign w_bit_end = w_tick && (r_tick_cnt == LAST_TICK);

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      w_next  = r_state;
      w_pop   = 1'b0;
      w_pin_d = LINE_IDLE;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop  = 1'b1;
               w_next = ST_START;
            end
         end
         ST_START: begin
            w_pin_d = 1'b0;
            if (w_bit_end) w_next = ST_DATA;
         end
         ST_DATA: begin
            w_pin_d = r_shift[0];
            if (w_bit_end && (r_bit_cnt == LAST_BIT)) w_next = ST_STOP;
         end
         ST_STOP: begin
            // Pop straight into the next start bit so queued bytes go out without an idle gap.
            if (w_bit_end && (r_stop_cnt == LAST_STOP)) begin
               if (!w_empty) begin
                  w_pop  = 1'b1;
                  w_next = ST_START;
               end else begin
                  w_next = ST_IDLE;
               end
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_res) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge i_clk) begin
      if (i_res) begin
         r_tx_pin   <= LINE_IDLE;
         r_shift    <= '0;
         r_baud_l   <= '0;
         r_baud_cnt <= '0;
         r_tick_cnt <= '0;
         r_bit_cnt  <= '0;
         r_stop_cnt <= 1'b0;
      end else begin
         r_tx_pin <= w_pin_d;
         if (w_pop) begin
            // Frame start: baud is frozen here so later i_baud changes wait for the next frame.
            r_shift    <= w_fifo_data;
            r_baud_l   <= i_baud;
            r_baud_cnt <= '0;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
         end else if (w_tick) begin
            r_baud_cnt <= '0;
            r_tick_cnt <= r_tick_cnt + 3'd1;
            if (r_tick_cnt == LAST_TICK) begin
               if (r_state == ST_DATA) begin
                  r_shift   <= r_shift >> 1;
                  r_bit_cnt <= r_bit_cnt + 3'd1;
               end
               if (r_state == ST_STOP) r_stop_cnt <= r_stop_cnt + 1'b1;
            end
         end else if (r_state != ST_IDLE) begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo_core.sv
// Self-checking bench for uart_tx_fifo_core: table-driven single frames plus
// scoreboarded multi-frame sequences on three parameterisations.
module tb_uart_tx_fifo_core;

   logic        clk = 1'b0;
   logic        res0, res1, res2;
   logic [15:0] baud0, baud1, baud2;
   logic        pin0, pin1, pin2;
   logic        busy0, busy1, busy2;
   logic [4:0]  cnt0;
   logic [2:0]  cnt1;
   logic [4:0]  cnt2;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [7:0]  exp_q[$];

   uart_tx_fifo_core_if if0 ();
   uart_tx_fifo_core_if if1 ();
   uart_tx_fifo_core_if if2 ();

   uart_tx_fifo_core #(.FIFO_DEPTH(16), .STOP_BITS(1)) dut0 (
      .i_clk(clk), .i_res(res0), .i_baud(baud0), .io_tx(if0),
      .o_tx_pin(pin0), .o_busy(busy0), .o_fifoCount(cnt0));
   uart_tx_fifo_core #(.FIFO_DEPTH(4), .STOP_BITS(1)) dut1 (
      .i_clk(clk), .i_res(res1), .i_baud(baud1), .io_tx(if1),
      .o_tx_pin(pin1), .o_busy(busy1), .o_fifoCount(cnt1));
   uart_tx_fifo_core #(.FIFO_DEPTH(16), .STOP_BITS(2)) dut2 (
      .i_clk(clk), .i_res(res2), .i_baud(baud2), .io_tx(if2),
      .o_tx_pin(pin2), .o_busy(busy2), .o_fifoCount(cnt2));

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, run did not complete");
      $fatal(1);
   end

   typedef struct {
      logic [7:0]  data;
      logic [15:0] baud;
      logic [9:0]  line;   // bit i = level of the i-th bit on the wire (start..stop)
   } vec_t;

   vec_t vecs[6];

   task automatic step();
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic pin_of(input int sel);
      case (sel)
         0:       return pin0;
         1:       return pin1;
         default: return pin2;
      endcase
   endfunction

   // One-cycle write starting at a negedge; returns at the negedge after the write edge.
   task automatic wr(input int sel, input logic [7:0] data, input bit push_sb);
      case (sel)
         0:       begin if0.i_txValid = 1'b1; if0.i_txData = data; end
         1:       begin if1.i_txValid = 1'b1; if1.i_txData = data; end
         default: begin if2.i_txValid = 1'b1; if2.i_txData = data; end
      endcase
      if (push_sb) exp_q.push_back(data);
      step();
      if0.i_txValid = 1'b0;
      if1.i_txValid = 1'b0;
      if2.i_txValid = 1'b0;
   endtask

   // Waits for a start bit, then walks the whole frame sampling every clock.
   task automatic recv_frame(input int sel, input int bclk, input int nstop, input int limit,
                             output logic [7:0] d, output int waited, output int lows,
                             output int stop_hi, output bit to);
      logic p;
      d = '0; waited = 0; lows = 0; stop_hi = 0; to = 1'b0;
      while (pin_of(sel) && waited < limit) begin
         step();
         waited++;
      end
      if (pin_of(sel)) begin
         to = 1'b1;
         return;
      end
      for (int t = 0; t < (9 + nstop) * bclk; t++) begin
         p = pin_of(sel);
         if (!p) lows++;
         if (t >= 9 * bclk && p) stop_hi++;
         if (t >= bclk && t < 9 * bclk && (t % bclk) == bclk / 2) d[t / bclk - 1] = p;
         step();
      end
   endtask

   task automatic score(input string tag, input logic [7:0] d, input int lows, input int stop_hi,
                        input int bclk, input int nstop, input bit to);
      logic [7:0] e;
      check({tag, " timeout"}, 32'(to), 32'd0);
      check({tag, " scoreboard entry present"}, 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check({tag, " data"}, 32'(d), 32'(e));
         check({tag, " low clocks"}, 32'(lows), 32'(bclk * (9 - $countones(e))));
         check({tag, " stop high clocks"}, 32'(stop_hi), 32'(nstop * bclk));
      end
   endtask

   initial begin
      logic [7:0] d;
      int         waited, lows, stop_hi, bclk, errs;
      bit         to;
      logic [9:0] first_pat, last_pat;
      logic       p, busy_pre, busy_post;

      vecs[0] = '{8'h55, 16'd3, 10'h2AA};
      vecs[1] = '{8'h00, 16'd0, 10'h200};
      vecs[2] = '{8'hFF, 16'd1, 10'h3FE};
      vecs[3] = '{8'hA3, 16'd2, 10'h346};
      vecs[4] = '{8'h80, 16'd0, 10'h300};
      vecs[5] = '{8'h01, 16'd5, 10'h202};

      if0.i_txValid = 1'b0; if0.i_txData = '0;
      if1.i_txValid = 1'b0; if1.i_txData = '0;
      if2.i_txValid = 1'b0; if2.i_txData = '0;
      baud0 = '0; baud1 = '0; baud2 = '0;
      res0 = 1'b1; res1 = 1'b1; res2 = 1'b1;

      // Reset held for three edges.
      repeat (3) step();
      check("reset pin", 32'(pin0), 32'd1);
      check("reset ready", 32'(if0.o_txReady), 32'd1);
      check("reset busy", 32'(busy0), 32'd0);
      check("reset count", 32'(cnt0), 32'd0);
      check("reset busy dut1", 32'(busy1), 32'd0);
      check("reset pin dut2", 32'(pin2), 32'd1);
      res0 = 1'b0; res1 = 1'b0; res2 = 1'b0;
      repeat (2) step();

      // Single frames from the table: exact 2-clock latency, bit edges, busy fall.
      foreach (vecs[i]) begin
         baud0 = vecs[i].baud;
         bclk  = 8 * (int'(vecs[i].baud) + 1);
         wr(0, vecs[i].data, 1'b0);
         check($sformatf("vec%0d count after write", i), 32'(cnt0), 32'd1);
         step();
         check($sformatf("vec%0d line high 1 clk after write", i), 32'(pin0), 32'd1);
         step();
         first_pat = '0; last_pat = '0; busy_pre = 1'b0; busy_post = 1'b1;
         for (int t = 0; t < 10 * bclk; t++) begin
            p = pin0;
            if (t % bclk == 0)        first_pat[t / bclk] = p;
            if (t % bclk == bclk - 1) last_pat[t / bclk]  = p;
            if (t == 10 * bclk - 2)   busy_pre  = busy0;
            if (t == 10 * bclk - 1)   busy_post = busy0;
            step();
         end
         check($sformatf("vec%0d bit first clocks", i), 32'(first_pat), 32'(vecs[i].line));
         check($sformatf("vec%0d bit last clocks", i), 32'(last_pat), 32'(vecs[i].line));
         check($sformatf("vec%0d busy before frame end", i), 32'(busy_pre), 32'd1);
         check($sformatf("vec%0d busy after frame end", i), 32'(busy_post), 32'd0);
      end

      // Back-to-back at i_baud=0: second start bit directly after the first stop bit.
      baud0 = 16'd0;
      wr(0, 8'hA3, 1'b1);
      wr(0, 8'h0F, 1'b1);
      recv_frame(0, 8, 1, 20, d, waited, lows, stop_hi, to);
      score("b2b frame0", d, lows, stop_hi, 8, 1, to);
      recv_frame(0, 8, 1, 20, d, waited, lows, stop_hi, to);
      score("b2b frame1", d, lows, stop_hi, 8, 1, to);
      check("b2b idle gap", 32'(waited), 32'd0);
      repeat (4) step();

      // FIFO full on a depth-4 instance: six writes, the sixth is dropped.
      baud1 = 16'd7;
      fork
         begin
            wr(1, 8'h11, 1'b1);
            wr(1, 8'h22, 1'b1);
            wr(1, 8'h33, 1'b1);
            wr(1, 8'h44, 1'b1);
            wr(1, 8'h55, 1'b1);
            check("full ready low", 32'(if1.o_txReady), 32'd0);
            check("full count", 32'(cnt1), 32'd4);
            wr(1, 8'h66, 1'b0);
            check("full count after dropped write", 32'(cnt1), 32'd4);
         end
         begin
            for (int k = 0; k < 5; k++) begin
               recv_frame(1, 64, 1, 20, d, waited, lows, stop_hi, to);
               score($sformatf("full frame%0d", k), d, lows, stop_hi, 64, 1, to);
               if (k > 0) check($sformatf("full frame%0d gap", k), 32'(waited), 32'd0);
            end
            recv_frame(1, 64, 1, 300, d, waited, lows, stop_hi, to);
            check("full no sixth frame", 32'(to), 32'd1);
            check("full busy cleared", 32'(busy1), 32'd0);
         end
      join

      // Baud change during DATA only affects the following frame.
      baud0 = 16'd1;
      wr(0, 8'hFF, 1'b1);
      wr(0, 8'h96, 1'b1);
      fork
         begin
            recv_frame(0, 16, 1, 20, d, waited, lows, stop_hi, to);
            score("baud frame0", d, lows, stop_hi, 16, 1, to);
            recv_frame(0, 40, 1, 20, d, waited, lows, stop_hi, to);
            score("baud frame1", d, lows, stop_hi, 40, 1, to);
            check("baud frame1 gap", 32'(waited), 32'd0);
         end
         begin
            repeat (60) step();
            baud0 = 16'd4;
         end
      join
      repeat (4) step();

      // Two stop bits: 16 high clocks before the next start bit.
      baud2 = 16'd0;
      wr(2, 8'h00, 1'b1);
      wr(2, 8'h00, 1'b1);
      recv_frame(2, 8, 2, 20, d, waited, lows, stop_hi, to);
      score("stop2 frame0", d, lows, stop_hi, 8, 2, to);
      recv_frame(2, 8, 2, 20, d, waited, lows, stop_hi, to);
      score("stop2 frame1", d, lows, stop_hi, 8, 2, to);
      check("stop2 gap", 32'(waited), 32'd0);

      // Reset mid-frame with a byte still queued: line high next edge, nothing resumes.
      baud0 = 16'd3;
      wr(0, 8'h00, 1'b0);
      repeat (40) step();
      wr(0, 8'h5A, 1'b0);
      check("pre-reset line low", 32'(pin0), 32'd0);
      check("pre-reset count", 32'(cnt0), 32'd1);
      res0 = 1'b1;
      step();
      check("mid reset pin", 32'(pin0), 32'd1);
      check("mid reset count", 32'(cnt0), 32'd0);
      check("mid reset ready", 32'(if0.o_txReady), 32'd1);
      check("mid reset busy", 32'(busy0), 32'd0);
      repeat (2) step();
      res0 = 1'b0;
      errs = 0;
      for (int t = 0; t < 200; t++) begin
         step();
         if (pin0 !== 1'b1 || busy0 !== 1'b0) errs++;
      end
      check("no frame after reset", 32'(errs), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
